// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matching, a registered match pulse and a saturating match counter.
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1010),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      din_valid,
  input  logic                      din,
  input  logic                      cfg_load,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]  cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      cnt_clr,
  output logic                      dout,
  output logic [CNT_W-1:0]          match_count,
  output logic                      count_sat
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  // Out-of-range lengths are stored as 0, which disables matching.
  function automatic logic [LEN_W-1:0] legal_len(input logic [LEN_W-1:0] len);
    return (len == '0 || len > FILL_MAX) ? '0 : len;
  endfunction

  localparam logic [LEN_W-1:0] DEF_LEN_Q = legal_len(LEN_W'(DEF_LEN));

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_dout;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_count_sat;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_next;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], din};
    w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    w_mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end

    // A match needs enough bits since the last clear and the newest len bits equal to the pattern.
    w_match = din_valid && !cfg_load && (r_len != '0) && (w_fill_next >= r_len) &&
              (((w_hist_next ^ r_pattern) & w_mask) == '0);

    w_cnt_next = r_match_count;
    if (cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_match && !(&r_match_count)) begin
      w_cnt_next = r_match_count + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge (synchronous).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pattern     <= DEF_PATTERN;
      r_len         <= DEF_LEN_Q;
      r_overlap     <= DEF_OVERLAP;
      r_hist        <= '0;
      r_fill        <= '0;
      r_dout        <= 1'b0;
      r_match_count <= '0;
      r_count_sat   <= 1'b0;
    end else begin
      r_dout        <= w_match;
      r_match_count <= w_cnt_next;
      r_count_sat   <= &w_cnt_next;
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= legal_len(cfg_len);
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (din_valid) begin
        r_hist <= w_hist_next;
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
      end
    end
  end

  assign dout        = r_dout;
  assign match_count = r_match_count;
  assign count_sat   = r_count_sat;

endmodule
